// File: rtl/mem_check_pkg.sv
// mem_check_pkg: shared state encoding and failure codes for mem_write_checker
package mem_check_pkg;
  typedef enum logic [1:0] {RUN, PASS, FAIL} state_t;
  localparam logic [1:0] FC_NONE    = 2'd0;
  localparam logic [1:0] FC_DATA    = 2'd1;
  localparam logic [1:0] FC_ADDR    = 2'd2;
  localparam logic [1:0] FC_TIMEOUT = 2'd3;
endpackage

// File: rtl/progress_timer.sv
// progress_timer: counts consecutive no-progress cycles and flags the last allowed one
module progress_timer #(
  parameter int TIMEOUT = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic expired
);
  localparam int W = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  logic [W-1:0] count;
  // restart on progress, advance on every idle cycle
  always_ff @(posedge clk or posedge reset)
    if (reset) count <= '0;
    else if (clear) count <= '0;
    else if (en) count <= count + W'(1);
  assign expired = (TIMEOUT != 0) && en && (count == W'(TIMEOUT - 1));
endmodule

// File: rtl/mem_write_checker.sv
// mem_write_checker: checks an ordered list of expected data-memory writes in hardware
module mem_write_checker
  import mem_check_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int N_EXP   = 4,
  parameter int TIMEOUT = 1000,
  parameter int STRICT  = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         MemWrite,
  input  logic [ADDR_W-1:0]            DataAdr,
  input  logic [DATA_W-1:0]            WriteData,
  input  logic [N_EXP*ADDR_W-1:0]      exp_addr,
  input  logic [N_EXP*DATA_W-1:0]      exp_data,
  output logic                         done,
  output logic                         pass,
  output logic [1:0]                   fail_code,
  output logic [$clog2(N_EXP+1)-1:0]   match_count,
  output logic [ADDR_W-1:0]            fail_addr,
  output logic [DATA_W-1:0]            fail_data,
  output logic [31:0]                  cycles
);
  localparam int CW = $clog2(N_EXP + 1);
  state_t            state, state_n;
  logic [CW-1:0]     count_n;
  logic [1:0]        code_n;
  logic [ADDR_W-1:0] cur_addr, addr_n;
  logic [DATA_W-1:0] cur_data, data_n;
  logic              addr_hit, data_hit, progress, expired;
  // the entry awaited next is the one indexed by the match count
  always_comb begin
    cur_addr = '0;
    cur_data = '0;
    for (int i = 0; i < N_EXP; i++)
      if (match_count == CW'(i)) begin
        cur_addr = exp_addr[i*ADDR_W +: ADDR_W];
        cur_data = exp_data[i*DATA_W +: DATA_W];
      end
  end
  // if-based compares so that unknown inputs resolve to a clean miss
  always_comb begin
    addr_hit = 1'b0;
    data_hit = 1'b0;
    if (MemWrite && DataAdr == cur_addr) addr_hit = 1'b1;
    if (WriteData == cur_data) data_hit = 1'b1;
  end
  assign progress = (state == RUN) && addr_hit && data_hit;
  progress_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (progress),
    .en      (state == RUN && !progress),
    .expired (expired)
  );
  // next state and diagnostics; mismatches take priority over timer expiry
  always_comb begin
    state_n = state;
    count_n = match_count;
    code_n  = fail_code;
    addr_n  = fail_addr;
    data_n  = fail_data;
    if (state == RUN) begin
      if (progress) begin
        count_n = match_count + CW'(1);
        if (match_count == CW'(N_EXP - 1)) state_n = PASS;
      end else if (addr_hit) begin
        state_n = FAIL;
        code_n  = FC_DATA;
        addr_n  = DataAdr;
        data_n  = WriteData;
      end else if (MemWrite && STRICT != 0) begin
        state_n = FAIL;
        code_n  = FC_ADDR;
        addr_n  = DataAdr;
        data_n  = WriteData;
      end else if (expired) begin
        state_n = FAIL;
        code_n  = FC_TIMEOUT;
      end
    end
  end
  // state, status and saturating cycle counter registers
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state       <= RUN;
      done        <= 1'b0;
      pass        <= 1'b0;
      fail_code   <= FC_NONE;
      match_count <= '0;
      fail_addr   <= '0;
      fail_data   <= '0;
      cycles      <= '0;
    end else begin
      state       <= state_n;
      done        <= state_n != RUN;
      pass        <= state_n == PASS;
      fail_code   <= code_n;
      match_count <= count_n;
      fail_addr   <= addr_n;
      fail_data   <= data_n;
      if (state == RUN && cycles != 32'hFFFF_FFFF) cycles <= cycles + 32'd1;
    end
endmodule

// File: tb/tb_mem_write_checker.sv
// tb_mem_write_checker: three checker configurations against a write-list reference model
module tb_mem_write_checker;
  localparam int TO = 10;
  localparam int RUNNING = 0, PASSED = 1, FAILED = 2;
  logic clk = 1'b0, reset = 1'b0, MemWrite = 1'b0;
  logic [31:0] DataAdr = '0, WriteData = '0;
  logic [95:0] exp_addr3 = '0, exp_data3 = '0;
  logic [31:0] exp_addr1 = '0, exp_data1 = '0;
  logic        done_o[3], pass_o[3];
  logic [1:0]  code_o[3];
  logic [31:0] fa_o[3], fd_o[3], cyc_o[3];
  logic [1:0]  mc0, mc1;
  logic        mc2;
  int          total = 0, bad = 0;
  int          nexp[3] = '{3, 3, 1};
  bit          strict[3] = '{1'b0, 1'b1, 1'b0};
  logic [31:0] ea[3][3], ed[3][3];
  int          m_st[3], m_idx[3], m_idle[3];
  logic [1:0]  m_code[3];
  logic [31:0] m_fa[3], m_fd[3];
  longint      m_cyc[3];

  always #5 clk = ~clk;

  mem_write_checker #(.ADDR_W(32), .DATA_W(32), .N_EXP(3), .TIMEOUT(TO), .STRICT(0)) u0 (
    .clk(clk), .reset(reset), .MemWrite(MemWrite), .DataAdr(DataAdr), .WriteData(WriteData),
    .exp_addr(exp_addr3), .exp_data(exp_data3), .done(done_o[0]), .pass(pass_o[0]),
    .fail_code(code_o[0]), .match_count(mc0), .fail_addr(fa_o[0]), .fail_data(fd_o[0]), .cycles(cyc_o[0]));
  mem_write_checker #(.ADDR_W(32), .DATA_W(32), .N_EXP(3), .TIMEOUT(TO), .STRICT(1)) u1 (
    .clk(clk), .reset(reset), .MemWrite(MemWrite), .DataAdr(DataAdr), .WriteData(WriteData),
    .exp_addr(exp_addr3), .exp_data(exp_data3), .done(done_o[1]), .pass(pass_o[1]),
    .fail_code(code_o[1]), .match_count(mc1), .fail_addr(fa_o[1]), .fail_data(fd_o[1]), .cycles(cyc_o[1]));
  mem_write_checker #(.ADDR_W(32), .DATA_W(32), .N_EXP(1), .TIMEOUT(TO), .STRICT(0)) u2 (
    .clk(clk), .reset(reset), .MemWrite(MemWrite), .DataAdr(DataAdr), .WriteData(WriteData),
    .exp_addr(exp_addr1), .exp_data(exp_data1), .done(done_o[2]), .pass(pass_o[2]),
    .fail_code(code_o[2]), .match_count(mc2), .fail_addr(fa_o[2]), .fail_data(fd_o[2]), .cycles(cyc_o[2]));

  function automatic logic [1:0] mcv(input int k);
    return k == 0 ? mc0 : k == 1 ? mc1 : {1'b0, mc2};
  endfunction

  task automatic chk(input string nm, input int k, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s u%0d t=%0t got=%0h want=%0h", nm, k, $time, got, want);
    end
  endtask

  // reference: walk the expected list, count consecutive idle edges, latch the first failure
  always @(posedge clk or posedge reset) begin
    for (int k = 0; k < 3; k++)
      if (reset) begin
        m_st[k] <= RUNNING; m_idx[k] <= 0; m_idle[k] <= 0;
        m_code[k] <= 2'd0; m_fa[k] <= '0; m_fd[k] <= '0; m_cyc[k] <= 0;
      end else if (m_st[k] == RUNNING) begin
        m_cyc[k] <= m_cyc[k] < 64'hFFFF_FFFF ? m_cyc[k] + 1 : m_cyc[k];
        if (MemWrite && DataAdr == ea[k][m_idx[k]] && WriteData == ed[k][m_idx[k]]) begin
          m_idx[k] <= m_idx[k] + 1;
          m_idle[k] <= 0;
          if (m_idx[k] + 1 == nexp[k]) m_st[k] <= PASSED;
        end else if (MemWrite && (DataAdr == ea[k][m_idx[k]] || strict[k])) begin
          m_st[k] <= FAILED;
          m_code[k] <= DataAdr == ea[k][m_idx[k]] ? 2'd1 : 2'd2;
          m_fa[k] <= DataAdr;
          m_fd[k] <= WriteData;
        end else if (m_idle[k] + 1 == TO) begin
          m_st[k] <= FAILED;
          m_code[k] <= 2'd3;
        end else m_idle[k] <= m_idle[k] + 1;
      end
  end

  // compare every cycle, well away from the rising edge
  always @(negedge clk) begin
    #2;
    for (int k = 0; k < 3; k++) begin
      chk("done", k, done_o[k], m_st[k] != RUNNING);
      chk("pass", k, pass_o[k], m_st[k] == PASSED);
      chk("fail_code", k, code_o[k], m_code[k]);
      chk("match_count", k, mcv(k), m_idx[k]);
      chk("fail_addr", k, fa_o[k], m_fa[k]);
      chk("fail_data", k, fd_o[k], m_fd[k]);
      chk("cycles", k, cyc_o[k], m_cyc[k]);
    end
  end

  task automatic drive(input logic mw, input logic [31:0] a, input logic [31:0] d);
    MemWrite = mw; DataAdr = a; WriteData = d;
  endtask
  task automatic cyc(input logic mw, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    drive(mw, a, d);
  endtask
  task automatic rst_on;
    @(negedge clk);
    reset = 1'b1;
    drive(1'b0, '0, '0);
  endtask
  task automatic rst_off;
    @(negedge clk);
    reset = 1'b0;
  endtask
  task automatic set3(input logic [31:0] a0, d0, a1, d1, a2, d2);
    ea[0] = '{a0, a1, a2}; ed[0] = '{d0, d1, d2};
    ea[1] = ea[0]; ed[1] = ed[0];
    exp_addr3 = {a2, a1, a0};
    exp_data3 = {d2, d1, d0};
  endtask
  task automatic set1(input logic [31:0] a, d);
    ea[2] = '{a, 32'd0, 32'd0}; ed[2] = '{d, 32'd0, 32'd0};
    exp_addr1 = a;
    exp_data1 = d;
  endtask

  initial begin
    logic [31:0] base;
    int k, j, o, r, s, idle_pct;
    rst_on;
    set3(32'd100, 32'd1, 32'd104, 32'd2, 32'd108, 32'd3);
    set1(32'd128, 32'hFE);
    #1;
    chk("rst_done", 2, done_o[2], 0);
    chk("rst_match", 0, mc0, 0);
    chk("rst_cycles", 1, cyc_o[1], 0);
    rst_off;
    // single entry: stray write ignored, then the match
    cyc(1, 32'h40, 32'h10); cyc(1, 32'd128, 32'hFE); cyc(0, 0, 0); #3;
    chk("t1_pass", 2, pass_o[2], 1);
    chk("t1_done", 2, done_o[2], 1);
    chk("t1_match", 2, mc2, 1);
    chk("t1_code", 2, code_o[2], 0);
    // single entry: right address, wrong data
    rst_on; rst_off;
    cyc(1, 32'd128, 32'hFF); cyc(0, 0, 0); #3;
    chk("t2_done", 2, done_o[2], 1);
    chk("t2_pass", 2, pass_o[2], 0);
    chk("t2_code", 2, code_o[2], 1);
    chk("t2_addr", 2, fa_o[2], 128);
    chk("t2_data", 2, fd_o[2], 32'hFF);
    // strict: unexpected address after one match
    rst_on; rst_off;
    cyc(1, 32'd100, 32'd1); cyc(1, 32'd200, 32'd7); cyc(0, 0, 0); #3;
    chk("t3_code", 1, code_o[1], 2);
    chk("t3_match", 1, mc1, 1);
    chk("t3_addr", 1, fa_o[1], 200);
    chk("t3_lax_done", 0, done_o[0], 0);
    // timeout on the tenth idle edge, cycles then frozen
    rst_on; rst_off;
    repeat (9) cyc(0, 0, 0);
    #3 chk("t4_early", 0, done_o[0], 0);
    cyc(0, 0, 0); #3;
    chk("t4_code", 0, code_o[0], 3);
    chk("t4_cycles", 0, cyc_o[0], 10);
    chk("t4_addr", 0, fa_o[0], 0);
    repeat (3) cyc(0, 0, 0);
    #3 chk("t4_frozen", 0, cyc_o[0], 10);
    // progress every ninth edge keeps the timer alive
    rst_on; rst_off;
    for (int e = 2; e <= 31; e++)
      if (e == 9 || e == 18 || e == 27) cyc(1, ea[0][e/9-1], ed[0][e/9-1]);
      else cyc(0, 0, 0);
    #3;
    chk("t5_pass", 0, pass_o[0], 1);
    chk("t5_strict_pass", 1, pass_o[1], 1);
    // final match lands on the expiry edge: progress wins
    rst_on; rst_off;
    for (int e = 2; e <= 31; e++)
      if (e == 10 || e == 20 || e == 30) cyc(1, ea[0][e/10-1], ed[0][e/10-1]);
      else cyc(0, 0, 0);
    #3;
    chk("t5b_pass", 0, pass_o[0], 1);
    chk("t5b_code", 0, code_o[0], 0);
    chk("t5b_cycles", 0, cyc_o[0], 30);
    // asynchronous reset mid-run, then the full sequence
    rst_on; rst_off;
    cyc(1, 32'd100, 32'd1);
    repeat (3) cyc(0, 0, 0);
    #3 chk("t6_before", 0, mc0, 1);
    reset = 1'b1;
    #1;
    chk("t6_match", 0, mc0, 0);
    chk("t6_cycles", 0, cyc_o[0], 0);
    rst_off;
    cyc(1, 32'd100, 32'd1); cyc(1, 32'd104, 32'd2); cyc(1, 32'd108, 32'd3); cyc(0, 0, 0); #3;
    chk("t6_pass", 0, pass_o[0], 1);
    chk("t6_count", 0, mc0, 3);
    chk("t6_cycles_end", 0, cyc_o[0], 4);
    // randomized episodes
    for (int ep = 0; ep < 40; ep++) begin
      rst_on;
      base = $urandom & 32'h0000_FFF0;
      set3(base, $urandom, base + 32'd4, $urandom, base + 32'd8, $urandom);
      set1($urandom_range(1) != 0 ? base : base + 32'h100, $urandom_range(1) != 0 ? ed[0][0] : $urandom);
      rst_off;
      idle_pct = $urandom_range(90);
      repeat (35) begin
        @(negedge clk);
        if ($urandom_range(99) < 2) begin
          reset = 1'b1;
          drive(1'b0, '0, '0);
          rst_off;
        end else begin
          k = $urandom_range(1) != 0 ? 0 : 2;
          j = m_idx[k] < nexp[k] ? m_idx[k] : 0;
          r = $urandom_range(99);
          s = $urandom_range(9);
          o = $urandom_range(nexp[k] - 1);
          if (r < idle_pct) drive(1'b0, $urandom, $urandom);
          else if (s < 5) drive(1'b1, ea[k][j], ed[k][j]);
          else if (s < 7) drive(1'b1, ea[k][j], ed[k][j] ^ (32'd1 << $urandom_range(31)));
          else if (s < 9) drive(1'b1, ea[k][o], ed[k][o]);
          else drive(1'b1, $urandom, $urandom);
        end
      end
    end
    @(negedge clk);
    #4;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
